// File: rtl/mp3_pkg.sv
// rtl/mp3_pkg.sv - shared types and constants for the MP3 playback sequencer
package mp3_pkg;

  localparam int SEL_W_DEF = 4;

  localparam logic [1:0] MODE_QUEUE  = 2'b00;
  localparam logic [1:0] MODE_RETRIG = 2'b01;
  localparam logic [1:0] MODE_DROP   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } play_state_t;

endpackage

// File: rtl/mp3_play_ctrl_if.sv
// rtl/mp3_play_ctrl_if.sv - classifier intake and MP3 driver handshake bundle
interface mp3_play_ctrl_if
  import mp3_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
);

  logic             valid_in;
  logic [SEL_W-1:0] decision;
  logic [1:0]       mode;
  logic             drv_done;
  logic             drv_run;
  logic [SEL_W-1:0] drv_sel;

  modport master (
    output valid_in, decision, mode, drv_done,
    input  drv_run, drv_sel
  );

  modport slave (
    input  valid_in, decision, mode, drv_done,
    output drv_run, drv_sel
  );

endinterface

// File: rtl/mp3_play_ctrl_fifo.sv
// rtl/mp3_play_ctrl_fifo.sv - pending-clip queue with flush; flush+push keeps only the new entry
module play_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full queue may still take a push.
  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (flush && push)
      mem[0] <= din;
    else if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mp3_play_ctrl.sv
// rtl/mp3_play_ctrl.sv - playback sequencer: intake policy, clip queue, driver reset/play/gap FSM
module mp3_play_ctrl
  import mp3_pkg::*;
#(
  parameter int SEL_W      = SEL_W_DEF,
  parameter int N_CLIPS    = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_HOLD   = 16,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  mp3_play_ctrl_if.slave                  ifc,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] q_count,
  output logic                            drop_pulse
);

  localparam int HW = $clog2(RST_HOLD+1);
  localparam int GW = $clog2(GAP_CYCLES+1);

  play_state_t      state;
  logic [HW-1:0]    hold_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             reload;
  logic             drv_run_q;
  logic [SEL_W-1:0] drv_sel_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [SEL_W-1:0] head;
  logic             valid_clip;
  logic             push;
  logic             pop;
  logic             flush;
  logic             abort;

  assign ifc.drv_run = drv_run_q;
  assign ifc.drv_sel = drv_sel_q;

  // After an abort the FSM sits in HOLD with reload set and pops the new clip from there,
  // so a retrigger never passes through IDLE and busy stays high.
  always_comb begin
    valid_clip = ifc.valid_in && (int'(ifc.decision) < N_CLIPS);
    flush      = valid_clip && (ifc.mode == MODE_RETRIG);
    abort      = flush && (state != IDLE);
    pop        = !flush && !fifo_empty && ((state == IDLE) || (state == HOLD && reload));
    case (ifc.mode)
      MODE_RETRIG: push = valid_clip;
      MODE_DROP:   push = valid_clip && (state == IDLE) && fifo_empty;
      default:     push = valid_clip && (!fifo_full || pop);
    endcase
  end

  play_fifo #(
    .W     (SEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (ifc.decision),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      drv_run_q  <= 1'b0;
      drv_sel_q  <= '0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      reload     <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= ifc.valid_in && !push;
      if (abort) begin
        state     <= HOLD;
        busy      <= 1'b1;
        drv_run_q <= 1'b0;
        reload    <= 1'b1;
        hold_cnt  <= HW'(RST_HOLD);
        gap_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              drv_sel_q <= head;
              hold_cnt  <= HW'(RST_HOLD);
              state     <= HOLD;
              busy      <= 1'b1;
            end
          end
          HOLD: begin
            if (reload) begin
              reload <= 1'b0;
              if (pop) begin
                drv_sel_q <= head;
                hold_cnt  <= HW'(RST_HOLD);
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else if (hold_cnt == '0) begin
              state     <= PLAY;
              drv_run_q <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end
          PLAY: begin
            if (ifc.drv_done) begin
              state     <= GAP;
              drv_run_q <= 1'b0;
              gap_cnt   <= GW'(GAP_CYCLES);
            end
          end
          GAP: begin
            if (gap_cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - GW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mp3_play_ctrl.sv
// tb/tb_mp3_play_ctrl.sv - directed self-checking bench for mp3_play_ctrl
module tb_mp3_play_ctrl;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [2:0] q_count;
  logic       drop_pulse;
  int         vectors;
  int         miscompares;

  mp3_play_ctrl_if #(.SEL_W(4)) bus ();

  mp3_play_ctrl #(
    .SEL_W      (4),
    .N_CLIPS    (10),
    .FIFO_DEPTH (4),
    .RST_HOLD   (4),
    .GAP_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ifc        (bus.slave),
    .busy       (busy),
    .q_count    (q_count),
    .drop_pulse (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] m, input logic [3:0] d);
    bus.mode     = m;
    bus.decision = d;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic done_pulse();
    bus.drv_done = 1'b1;
    tick();
    bus.drv_done = 1'b0;
  endtask

  task automatic wait_high(input int budget, output int low_cycles);
    low_cycles = 0;
    while (bus.drv_run !== 1'b1 && low_cycles < budget) begin
      low_cycles++;
      tick();
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    vectors++; if (bus.drv_run !== 1'b0) begin miscompares++; $display("FAIL reset_drv_run got=%0b exp=0", bus.drv_run); end
    vectors++; if (bus.drv_sel !== 4'd0) begin miscompares++; $display("FAIL reset_drv_sel got=%0d exp=0", bus.drv_sel); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    vectors++; if (q_count !== 3'd0) begin miscompares++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
    vectors++; if (drop_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_drop got=%0b exp=0", drop_pulse); end
  endtask

  task automatic test_single();
    strobe(2'b00, 4'd3);
    vectors++; if (q_count !== 3'd1) begin miscompares++; $display("FAIL single_push_q got=%0d exp=1", q_count); end
    tick();
    vectors++; if (bus.drv_sel !== 4'd3) begin miscompares++; $display("FAIL single_sel got=%0d exp=3", bus.drv_sel); end
    vectors++; if (q_count !== 3'd0) begin miscompares++; $display("FAIL single_pop_q got=%0d exp=0", q_count); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%0b exp=1", busy); end
    repeat (4) tick();
    vectors++; if (bus.drv_run !== 1'b0) begin miscompares++; $display("FAIL single_run_edge5 got=%0b exp=0", bus.drv_run); end
    tick();
    vectors++; if (bus.drv_run !== 1'b1) begin miscompares++; $display("FAIL single_run_edge6 got=%0b exp=1", bus.drv_run); end
    repeat (2) tick();
    done_pulse();
    vectors++; if (bus.drv_run !== 1'b0) begin miscompares++; $display("FAIL single_run_after_done got=%0b exp=0", bus.drv_run); end
    repeat (8) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_gap8 got=%0b exp=1", busy); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_gap9 got=%0b exp=0", busy); end
  endtask

  task automatic test_queue();
    int lc;
    int drops;
    strobe(2'b00, 4'd0);
    wait_high(20, lc);
    vectors++; if (lc !== 6) begin miscompares++; $display("FAIL queue_first_latency got=%0d exp=6", lc); end
    drops = 0;
    for (int d = 1; d <= 6; d++) begin
      strobe(2'b00, 4'(d));
      if (drop_pulse === 1'b1) drops++;
      vectors++; if (drop_pulse !== (d >= 5)) begin miscompares++; $display("FAIL queue_drop_%0d got=%0b exp=%0b", d, drop_pulse, (d >= 5)); end
    end
    vectors++; if (drops !== 2) begin miscompares++; $display("FAIL queue_drop_total got=%0d exp=2", drops); end
    vectors++; if (q_count !== 3'd4) begin miscompares++; $display("FAIL queue_count got=%0d exp=4", q_count); end
    for (int k = 0; k < 4; k++) begin
      repeat (2) tick();
      done_pulse();
      wait_high(40, lc);
      vectors++; if (bus.drv_run !== 1'b1) begin miscompares++; $display("FAIL queue_timeout_%0d got=%0b exp=1", k + 1, bus.drv_run); end
      vectors++; if (lc !== 15) begin miscompares++; $display("FAIL queue_low_gap_%0d got=%0d exp=15", k + 1, lc); end
      vectors++; if (bus.drv_sel !== 4'(k + 1)) begin miscompares++; $display("FAIL queue_order_%0d got=%0d exp=%0d", k + 1, bus.drv_sel, k + 1); end
      vectors++; if (q_count !== 3'(3 - k)) begin miscompares++; $display("FAIL queue_remaining_%0d got=%0d exp=%0d", k + 1, q_count, 3 - k); end
    end
    done_pulse();
    wait_idle(20);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL queue_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_retrigger();
    int lc;
    strobe(2'b00, 4'd1);
    wait_high(20, lc);
    strobe(2'b00, 4'd2);
    strobe(2'b00, 4'd3);
    vectors++; if (q_count !== 3'd2) begin miscompares++; $display("FAIL retrig_pre_count got=%0d exp=2", q_count); end
    bus.mode = 2'b01; bus.decision = 4'd7; bus.valid_in = 1'b1; bus.drv_done = 1'b1;
    tick();
    bus.valid_in = 1'b0; bus.drv_done = 1'b0; bus.mode = 2'b00;
    vectors++; if (q_count !== 3'd1) begin miscompares++; $display("FAIL retrig_count_a got=%0d exp=1", q_count); end
    vectors++; if (bus.drv_run !== 1'b0) begin miscompares++; $display("FAIL retrig_run_low got=%0b exp=0", bus.drv_run); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL retrig_busy got=%0b exp=1", busy); end
    tick();
    vectors++; if (q_count !== 3'd0) begin miscompares++; $display("FAIL retrig_count_b got=%0d exp=0", q_count); end
    vectors++; if (bus.drv_sel !== 4'd7) begin miscompares++; $display("FAIL retrig_sel got=%0d exp=7", bus.drv_sel); end
    wait_high(20, lc);
    vectors++; if (lc !== 5) begin miscompares++; $display("FAIL retrig_low_cycles got=%0d exp=5", lc); end
    vectors++; if (bus.drv_sel !== 4'd7) begin miscompares++; $display("FAIL retrig_sel_play got=%0d exp=7", bus.drv_sel); end
    done_pulse();
    wait_idle(20);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL retrig_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_drop_invalid();
    int lc;
    strobe(2'b00, 4'd5);
    wait_high(20, lc);
    strobe(2'b11, 4'd9);
    vectors++; if (drop_pulse !== 1'b0) begin miscompares++; $display("FAIL mode3_drop got=%0b exp=0", drop_pulse); end
    vectors++; if (q_count !== 3'd1) begin miscompares++; $display("FAIL mode3_count got=%0d exp=1", q_count); end
    done_pulse();
    repeat (2) tick();
    strobe(2'b10, 4'd2);
    vectors++; if (drop_pulse !== 1'b1) begin miscompares++; $display("FAIL dropbusy_gap got=%0b exp=1", drop_pulse); end
    vectors++; if (q_count !== 3'd1) begin miscompares++; $display("FAIL dropbusy_count got=%0d exp=1", q_count); end
    strobe(2'b01, 4'd12);
    vectors++; if (drop_pulse !== 1'b1) begin miscompares++; $display("FAIL invalid_retrig_drop got=%0b exp=1", drop_pulse); end
    vectors++; if (q_count !== 3'd1) begin miscompares++; $display("FAIL invalid_retrig_noflush got=%0d exp=1", q_count); end
    wait_high(40, lc);
    vectors++; if (bus.drv_sel !== 4'd9) begin miscompares++; $display("FAIL mode3_played got=%0d exp=9", bus.drv_sel); end
    done_pulse();
    wait_idle(20);
    strobe(2'b00, 4'd12);
    vectors++; if (drop_pulse !== 1'b1) begin miscompares++; $display("FAIL invalid_queue_drop got=%0b exp=1", drop_pulse); end
    strobe(2'b10, 4'd15);
    vectors++; if (drop_pulse !== 1'b1) begin miscompares++; $display("FAIL invalid_dropmode got=%0b exp=1", drop_pulse); end
    vectors++; if (q_count !== 3'd0) begin miscompares++; $display("FAIL invalid_count got=%0d exp=0", q_count); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL invalid_busy got=%0b exp=0", busy); end
    strobe(2'b10, 4'd4);
    vectors++; if (drop_pulse !== 1'b0) begin miscompares++; $display("FAIL dropbusy_idle_accept got=%0b exp=0", drop_pulse); end
    vectors++; if (q_count !== 3'd1) begin miscompares++; $display("FAIL dropbusy_idle_count got=%0d exp=1", q_count); end
    wait_high(20, lc);
    vectors++; if (bus.drv_sel !== 4'd4) begin miscompares++; $display("FAIL dropbusy_played got=%0d exp=4", bus.drv_sel); end
    done_pulse();
    wait_idle(20);
  endtask

  task automatic test_reset_mid();
    int lc;
    strobe(2'b00, 4'd1);
    wait_high(20, lc);
    strobe(2'b00, 4'd2);
    strobe(2'b00, 4'd3);
    strobe(2'b00, 4'd4);
    vectors++; if (q_count !== 3'd3) begin miscompares++; $display("FAIL rstmid_pre_count got=%0d exp=3", q_count); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.drv_run !== 1'b0) begin miscompares++; $display("FAIL rstmid_run got=%0b exp=0", bus.drv_run); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    vectors++; if (q_count !== 3'd0) begin miscompares++; $display("FAIL rstmid_count got=%0d exp=0", q_count); end
    tick();
    rst_n = 1'b1;
    done_pulse();
    repeat (5) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_stray_busy got=%0b exp=0", busy); end
    vectors++; if (bus.drv_run !== 1'b0) begin miscompares++; $display("FAIL rstmid_stray_run got=%0b exp=0", bus.drv_run); end
    vectors++; if (q_count !== 3'd0) begin miscompares++; $display("FAIL rstmid_stray_count got=%0d exp=0", q_count); end
  endtask

  task automatic test_back_to_back();
    int lc;
    strobe(2'b00, 4'd0);
    wait_high(20, lc);
    for (int d = 1; d <= 4; d++) strobe(2'b00, 4'(d));
    vectors++; if (q_count !== 3'd4) begin miscompares++; $display("FAIL b2b_full got=%0d exp=4", q_count); end
    tick();
    done_pulse();
    repeat (9) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got=%0b exp=0", busy); end
    strobe(2'b00, 4'd8);
    vectors++; if (drop_pulse !== 1'b0) begin miscompares++; $display("FAIL b2b_drop got=%0b exp=0", drop_pulse); end
    vectors++; if (q_count !== 3'd4) begin miscompares++; $display("FAIL b2b_count got=%0d exp=4", q_count); end
    vectors++; if (bus.drv_sel !== 4'd1) begin miscompares++; $display("FAIL b2b_sel got=%0d exp=1", bus.drv_sel); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got=%0b exp=1", busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.decision = '0;
    bus.mode     = 2'b00;
    bus.drv_done = 1'b0;
    repeat (2) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single();
    test_queue();
    test_retrigger();
    test_drop_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
